// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader on the write side of instruction memory.
// A 16-bit little-endian word count is followed by that many 32-bit little-endian
// words. The words are written to sequential word addresses starting at 0, and the
// CPU is held in stall until the image is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the data, a trailing byte must
// equal the 8-bit sum of all data bytes.
module imem_loader #(
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // State entered once the last data word (or an empty header) has been taken
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_FIN = ST_CSUM;
`else
  localparam state_e ST_FIN = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [23:0]        buf_q, buf_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               load_done_q, load_done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign len_full  = {byte_data, len_q[7:0]};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

  // Register update; every register returns to its idle value on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LEN_LO;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      buf_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      buf_q       <= buf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Next state: reload wins over any byte accepted in the same cycle
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = ST_LEN_LO;
    end else if (accept) begin
      case (state_q)
        ST_LEN_LO: state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (len_full == 16'd0)               state_d = ST_FIN;
          else if (32'(len_full) > DEPTH)      state_d = ST_ERR;
          else                                 state_d = ST_DATA;
        end
        ST_DATA: begin
          if (byte_idx_q == 2'd3 && last_word) state_d = ST_FIN;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM:   state_d = (byte_data == sum_q) ? ST_DONE : ST_ERR;
`endif
        default:   state_d = state_q;
      endcase
    end
  end

  // Byte handshake depends on state only
  always_comb begin
    case (state_q)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM:                       byte_ready = 1'b1;
`endif
      default:                       byte_ready = 1'b0;
    endcase
  end

  // Length capture, word assembly, write strobe and status outputs
  always_comb begin
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    buf_d       = buf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (reload) begin
      len_d      = '0;
      byte_idx_d = '0;
      word_cnt_d = '0;
      buf_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = '0;
`endif
    end else if (accept) begin
      case (state_q)
        ST_LEN_LO: len_d[7:0]  = byte_data;
        ST_LEN_HI: len_d[15:8] = byte_data;
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: buf_d[7:0]   = byte_data;
            2'd1: buf_d[15:8]  = byte_data;
            2'd2: buf_d[23:16] = byte_data;
            default: begin
              wr_en_d    = 1'b1;
              wr_data_d  = {byte_data, buf_q};
              wr_addr_d  = ADDR_W'(word_cnt_q);
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          endcase
        end
        default: ;
      endcase
    end
    cpu_hold_d  = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 16384;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              reload;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Captured memory writes
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(32'(wr_addr));
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cycle);
    end
  end

  // Stream to send and the image it should produce
  logic [7:0]  tx_q[$];
  logic [31:0] exp_data[$];

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_cyc.delete();
  endtask

  // Reference model: header, words split LSB first, optional trailing sum
  task automatic build_image(input int len);
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  sum;
    tx_q.delete();
    exp_data.delete();
    sum = 8'd0;
    tx_q.push_back(8'(len));
    tx_q.push_back(8'(len >> 8));
    if (len <= int'(DEPTH)) begin
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        exp_data.push_back(w);
        for (int k = 0; k < 4; k++) begin
          b = w[8*k +: 8];
          tx_q.push_back(b);
          sum = sum + b;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q.push_back(sum);
`endif
    end
  endtask

  // Offer each byte of tx_q; called and returns just after a falling edge
  task automatic drive_stream(input int max_gap);
    bit timed_out;
    int waited;
    timed_out = 1'b0;
    for (int i = 0; i < tx_q.size() && !timed_out; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          byte_valid = 1'b0;
          @(negedge clk);
        end
      end
      byte_valid = 1'b1;
      byte_data  = tx_q[i];
      waited = 0;
      while (byte_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) timed_out = 1'b1;
      else @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL stream_accept: byte_ready stayed low, got 0 required 1");
    end
  endtask

  task automatic do_reload(input bit with_byte, input logic [7:0] b);
    reload     = 1'b1;
    byte_valid = with_byte;
    byte_data  = b;
    @(negedge clk);
    reload     = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reload = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (wr_en !== 1'b0)       begin failures++; $display("FAIL reset_wr_en got %0b required 0", wr_en); end
    checks++; if (wr_addr !== '0)       begin failures++; $display("FAIL reset_wr_addr got %0h required 0", wr_addr); end
    checks++; if (wr_data !== 32'd0)    begin failures++; $display("FAIL reset_wr_data got %0h required 0", wr_data); end
    checks++; if (cpu_hold !== 1'b1)    begin failures++; $display("FAIL reset_cpu_hold got %0b required 1", cpu_hold); end
    checks++; if (load_done !== 1'b0)   begin failures++; $display("FAIL reset_load_done got %0b required 0", load_done); end
    checks++; if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got %0b required 0", err); end
    checks++; if (byte_ready !== 1'b1)  begin failures++; $display("FAIL reset_byte_ready got %0b required 1", byte_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_cap();
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'hB6);
`endif
    drive_stream(0);
    #1;
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL basic_done_first_cycle got %0b required 1", load_done); end
    checks++; if (cpu_hold !== 1'b0)  begin failures++; $display("FAIL basic_cpu_hold got %0b required 0", cpu_hold); end
    checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL basic_byte_ready got %0b required 0", byte_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (cap_addr.size() != 2) begin
      failures++; $display("FAIL basic_write_count got %0d required 2", cap_addr.size());
    end else begin
      if (cap_addr[0] !== 32'd0 || cap_data[0] !== 32'h0000_0013) begin
        failures++; $display("FAIL basic_word0 got %0h@%0h required 00000013@0", cap_data[0], cap_addr[0]);
      end
      checks++;
      if (cap_addr[1] !== 32'd1 || cap_data[1] !== 32'h0010_0093) begin
        failures++; $display("FAIL basic_word1 got %0h@%0h required 00100093@1", cap_data[1], cap_addr[1]);
      end
    end
  endtask

  task automatic test_len_zero();
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h00, 8'h00};
    drive_stream(0);
    #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++; if (load_done !== 1'b0 || byte_ready !== 1'b1) begin
      failures++; $display("FAIL len0_csum_wait got done=%0b ready=%0b required done=0 ready=1", load_done, byte_ready);
    end
    @(negedge clk);
    tx_q = '{8'h00};
    drive_stream(0);
    #1;
`endif
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL len0_done got done=%0b hold=%0b required done=1 hold=0", load_done, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++; if (cap_addr.size() != 0) begin failures++; $display("FAIL len0_no_write got %0d required 0", cap_addr.size()); end
  endtask

  task automatic test_too_long();
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h01, 8'h40};
    drive_stream(0);
    #1;
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0) begin
      failures++; $display("FAIL too_long_status got err=%0b hold=%0b ready=%0b done=%0b required 1 1 0 0", err, cpu_hold, byte_ready, load_done);
    end
    @(negedge clk);
    byte_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cap_addr.size() != 0) begin failures++; $display("FAIL too_long_no_write got %0d required 0", cap_addr.size()); end
    checks++; if (err !== 1'b1)         begin failures++; $display("FAIL too_long_sticky got %0b required 1", err); end
    do_reload(1'b0, 8'h00);
    checks++; if (err !== 1'b0 || byte_ready !== 1'b1) begin
      failures++; $display("FAIL too_long_reload got err=%0b ready=%0b required 0 1", err, byte_ready);
    end
    // Exactly DEPTH words is a legal image
    tx_q = '{8'h00, 8'h40};
    drive_stream(0);
    #1;
    checks++; if (err !== 1'b0 || byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL len_depth_ok got err=%0b ready=%0b hold=%0b required 0 1 1", err, byte_ready, cpu_hold);
    end
    @(negedge clk);
  endtask

  task automatic test_reload();
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drive_stream(0);
    repeat (2) @(negedge clk);
    checks++; if (cap_addr.size() != 1 || cap_data[0] !== 32'h4433_2211) begin
      failures++; $display("FAIL reload_pre_write got count=%0d required 1 of 44332211", cap_addr.size());
    end
    do_reload(1'b1, 8'hEE);
    #1;
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || err !== 1'b0 || byte_ready !== 1'b1) begin
      failures++; $display("FAIL reload_state got hold=%0b done=%0b err=%0b ready=%0b required 1 0 0 1", cpu_hold, load_done, err, byte_ready);
    end
    @(negedge clk);
    clear_cap();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h0E);
`endif
    drive_stream(0);
    repeat (2) @(negedge clk);
    checks++;
    if (cap_addr.size() != 1) begin
      failures++; $display("FAIL reload_write_count got %0d required 1", cap_addr.size());
    end else if (cap_addr[0] !== 32'd0 || cap_data[0] !== 32'hDDCC_BBAA) begin
      failures++; $display("FAIL reload_word got %0h@%0h required ddccbbaa@0", cap_data[0], cap_addr[0]);
    end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL reload_done got %0b required 1", load_done); end
  endtask

  task automatic test_back_to_back();
    do_reload(1'b0, 8'h00);
    clear_cap();
    build_image(4);
    drive_stream(0);
    repeat (2) @(negedge clk);
    checks++;
    if (cap_addr.size() != 4) begin
      failures++; $display("FAIL b2b_write_count got %0d required 4", cap_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_addr[i] !== 32'(i) || cap_data[i] !== exp_data[i]) begin
          failures++; $display("FAIL b2b_word%0d got %0h@%0h required %0h@%0h", i, cap_data[i], cap_addr[i], exp_data[i], i);
        end
        if (i > 0) begin
          checks++;
          if (cap_cyc[i] - cap_cyc[i-1] != 4) begin
            failures++; $display("FAIL b2b_spacing%0d got %0d required 4", i, cap_cyc[i] - cap_cyc[i-1]);
          end
        end
      end
    end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL b2b_done got %0b required 1", load_done); end
  endtask

  task automatic test_random();
    int len;
    bit bad;
    for (int it = 0; it < 10; it++) begin
      do_reload(1'b0, 8'h00);
      clear_cap();
      bad = ($urandom_range(0, 4) == 0);
      len = bad ? int'($urandom_range(DEPTH + 1, 65535)) : int'($urandom_range(1, 6));
      build_image(len);
      drive_stream(3);
      repeat (3) @(negedge clk);
      checks++;
      if (cap_addr.size() != exp_data.size()) begin
        failures++; $display("FAIL rand%0d_write_count got %0d required %0d", it, cap_addr.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if (cap_addr[i] !== 32'(i) || cap_data[i] !== exp_data[i]) begin
            failures++; $display("FAIL rand%0d_word%0d got %0h@%0h required %0h@%0h", it, i, cap_data[i], cap_addr[i], exp_data[i], i);
          end
        end
      end
      checks++;
      if (load_done !== !bad || err !== bad || cpu_hold !== bad) begin
        failures++; $display("FAIL rand%0d_status got done=%0b err=%0b hold=%0b required %0b %0b %0b", it, load_done, err, cpu_hold, !bad, bad, bad);
      end
    end
  endtask

  task automatic test_rst_midload();
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    drive_stream(0);
    #2 rst = 1'b1;
    #1;
    checks++; if (wr_addr !== '0 || wr_data !== 32'd0 || cpu_hold !== 1'b1 || byte_ready !== 1'b1 || load_done !== 1'b0) begin
      failures++; $display("FAIL rst_async got addr=%0h data=%0h hold=%0b ready=%0b done=%0b required 0 0 1 1 0", wr_addr, wr_data, cpu_hold, byte_ready, load_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_cap();
    build_image(1);
    drive_stream(0);
    repeat (2) @(negedge clk);
    checks++; if (cap_addr.size() != 1 || cap_addr[0] !== 32'd0 || cap_data[0] !== exp_data[0]) begin
      failures++; $display("FAIL rst_reload_word got count=%0d required 1 at addr 0", cap_addr.size());
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    drive_stream(0);
    #1;
    checks++; if (load_done !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL csum_good got done=%0b err=%0b required 1 0", load_done, err);
    end
    @(negedge clk);
    do_reload(1'b0, 8'h00);
    clear_cap();
    tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    drive_stream(0);
    #1;
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++; $display("FAIL csum_bad got err=%0b hold=%0b done=%0b required 1 1 0", err, cpu_hold, load_done);
    end
    checks++; if (cap_addr.size() != 1 || cap_data[0] !== 32'h0403_0201) begin
      failures++; $display("FAIL csum_bad_write got count=%0d required 1 of 04030201", cap_addr.size());
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_too_long();
    test_reload();
    test_back_to_back();
    test_random();
    test_rst_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader on the write side of instruction memory; the fetch stage is the read side.
- Receives a byte stream (from UART or debug bridge), assembles 32-bit little-endian words, and writes them to sequential word addresses of instruction memory starting at 0.
- Holds the CPU in stall while loading; releases it when the image is complete.
- Word addressing matches fetch: PC advances by 1 per instruction.

Parameters:
- DEPTH, 16384, instruction memory depth in words; the maximum loadable image.
- ADDR_W, 32, width of wr_addr (matches PC width).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- reload  input  1  one-cycle pulse; aborts any load and restarts at header.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  word to write.
- cpu_hold  output  1  drives the fetch stall and core hold; high while not DONE.
- load_done  output  1  image loaded successfully.
- err  output  1  load failed; sticky until reload or rst.

Behaviour:
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a combinational function of state only, never of byte_valid.
- States: LEN_LO, LEN_HI, DATA, CSUM (only with the macro), DONE, ERR.
- Reset (async) values:
  - state = LEN_LO; wr_en = 0; wr_addr = 0; wr_data = 0.
  - cpu_hold = 1; load_done = 0; err = 0.
  - Internal word count, byte index, and length register = 0.
- byte_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in DONE and ERR.
- LEN_LO: accepted byte goes to len[7:0] -> LEN_HI.
- LEN_HI: accepted byte goes to len[15:8]. The next state is decided on the completed 16-bit length L:
  - L == 0 -> DONE (or CSUM when the macro is defined).
  - L > DEPTH -> ERR.
  - Otherwise -> DATA.
- DATA assembly:
  - Bytes are assembled LSB first: byte k of a word goes to bits [8k+7:8k].
  - On acceptance of byte index 3, the next cycle shows wr_en = 1 for exactly one cycle, with wr_data = the assembled word and wr_addr = the word index (0, 1, 2, ...).
  - The word index increments after each write. Latency is one cycle from the 4th byte's accepting edge to the wr_en cycle.
- Back-to-back bytes at full rate are supported. wr_en may coincide with acceptance of the next word's first byte.
- After word L-1 is accepted -> DONE (or CSUM).
- DONE: load_done = 1 and cpu_hold = 0, both from the first cycle in DONE. No further writes occur.
- ERR: err = 1 and cpu_hold = 1. No writes occur; any remaining bytes are ignored (byte_ready = 0).
- reload pulse, from any state including mid-word:
  - Next cycle: state = LEN_LO; cpu_hold = 1; load_done = 0; err = 0.
  - Partial word is discarded; byte index = 0; word index = 0; wr_en = 0.
  - reload takes priority over a byte accepted in the same cycle; that byte is dropped.
- wr_addr width: word index zero-extended to ADDR_W; never exceeds DEPTH-1.
- rst asserted mid-load has the same effect as reload and also clears all registers immediately.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The CSUM state follows the last data word (or LEN_HI when L == 0).
  - One checksum byte is expected, equal to the 8-bit modular sum of all data bytes; length bytes are excluded.
  - The running sum resets on reload and rst.
  - Match -> DONE; mismatch -> ERR. Words already written are not undone; the CPU stays held.
- Not defined: no CSUM state, no running-sum logic; the last data word goes directly to DONE.

Test Plan:
- Reset, then stream 02 00 13 00 00 00 93 00 10 00 -> wr_en at addr 0 data 0x00000013, then addr 1 data 0x00100093; load_done=1; cpu_hold=0.
- Length 0 (00 00) -> no wr_en; DONE on the cycle after the 2nd byte (macro off).
- Length 0x4001 with DEPTH=16384 -> err=1; cpu_hold=1; byte_ready=0; no writes.
- Send len=2 plus 6 data bytes, pulse reload, then send a full 1-word image AA BB CC DD -> only one write, at addr 0, data 0xDDCCBBAA; load_done=1.
- Continuous byte_valid=1 for a 4-word image -> 4 wr_en pulses spaced exactly 4 cycles apart, addresses 0..3.
- With IMEM_LOADER_CHECKSUM_EN: 01 00 01 02 03 04 then 0A -> DONE; same image with checksum 0B -> err=1 and cpu_hold=1.
